// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state encoding
// and the funct3/alignment legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_RD   = RD;
    localparam logic [2:0] ST_WAIT = WAIT;
    localparam logic [2:0] ST_WR   = WR;
    localparam logic [2:0] ST_RESP = RESP;

    // Unsigned sizes only exist for loads, so BU/HU with we=1 are illegal stores.
    function automatic logic funct3_align_err(input logic we, input logic [2:0] f3,
                                              input logic [1:0] off);
        logic err;
        err = 1'b1;
        case (f3)
            F3_B:  err = 1'b0;
            F3_H:  err = off[0];
            F3_W:  err = (off != 2'b00);
            F3_BU: err = we;
            F3_HU: err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: extracts a sign/zero-extended load value from a
// memory word and merges byte/halfword store data into a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        is_half;

    assign sel_byte = word[{offset, 3'b000} +: 8];
    assign sel_half = offset[1] ? word[31:16] : word[15:0];
    assign is_half  = (funct3[1:0] == 2'b01);

    always_comb begin
        load_val = word;
        case (funct3)
            F3_B:  load_val = {{24{sel_byte[7]}}, sel_byte};
            F3_BU: load_val = {24'd0, sel_byte};
            F3_H:  load_val = {{16{sel_half[15]}}, sel_half};
            F3_HU: load_val = {16'd0, sel_half};
            default: load_val = word;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            // The odd byte of an addressed halfword takes the upper store byte.
            assign hit = is_half ? (offset[1] == LANE[1]) : (offset == LANE);
            assign src = (is_half && LANE[0]) ? wdata[15:8] : wdata[7:0];
            assign merged[8*gi +: 8] = hit ? src : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: serialises one load/store at a time onto a word-only memory port,
// using read-modify-write for byte and halfword stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

    logic [2:0]        state_reg, state_next;
    logic              we_reg;
    logic [2:0]        f3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       wdata_reg;
    logic [31:0]       word_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    logic [ADDR_W-1:0] req_index;
    logic              req_err;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign req_index = {2'b00, req_addr[ADDR_W-1:2]};
    assign req_err   = funct3_align_err(req_we, req_funct3, req_addr[1:0])
                     | (req_index >= DEPTH_LIM);

    lsu_align u_align (
        .word     (mem_rdata),
        .offset   (addr_reg[1:0]),
        .funct3   (f3_reg),
        .wdata    (wdata_reg),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD:   state_next = ST_WAIT;
            ST_WAIT: state_next = we_reg ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            we_reg    <= 1'b0;
            f3_reg    <= 3'd0;
            addr_reg  <= '0;
            wdata_reg <= 16'd0;
            word_reg  <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        f3_reg    <= req_funct3;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata[15:0];
                        // A full-word store goes straight to WR with this word.
                        word_reg  <= req_wdata;
                        rdata_reg <= 32'd0;
                        err_reg   <= req_err;
                    end
                end
                ST_WAIT: begin
                    if (we_reg)
                        word_reg <= merged;
                    else
                        rdata_reg <= load_val;
                end
                default: ;
            endcase
        end
    end

    // req_ready is masked by rst so every output reads 0 while reset is held.
    assign req_ready  = (state_reg == ST_IDLE) && !rst;
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign mem_read   = (state_reg == ST_RD);
    assign mem_write  = (state_reg == ST_WR);
    assign mem_addr   = (mem_read || mem_write) ? {2'b00, addr_reg[ADDR_W-1:2]} : '0;
    assign mem_wdata  = mem_write ? word_reg : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory (registered read).
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;

    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_nrd, r_nwr;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= mem[mem_addr[5:0]];
        if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    end

    // Strobe monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        if (hold > 0) resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r_lat = 1;
        while (!resp_valid && r_lat < 20) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_rdata = resp_rdata;
        r_err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, r_rdata);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if (hold > 0) begin
            chk("after_hs_valid", {31'd0, resp_valid}, 32'd0);
            chk("after_hs_ready", {31'd0, req_ready}, 32'd1);
        end
        r_nrd = rd_cnt - rd0;
        r_nwr = wr_cnt - wr0;
        $display("txn we=%0d f3=%03b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d rd=%0d wr=%0d",
                 we, f3, addr, wd, r_rdata, r_err, r_lat, r_nrd, r_nwr);
    endtask

    initial begin
        int wr0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);

        // Full-word store
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0);
        chk("sw_lat", 32'(r_lat), 32'd2);
        chk("sw_err", {31'd0, r_err}, 32'd0);
        chk("sw_rdata", r_rdata, 32'd0);
        chk("sw_nwr", 32'(r_nwr), 32'd1);
        chk("sw_nrd", 32'(r_nrd), 32'd0);
        chk("sw_waddr", last_waddr, 32'd4);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);

        // Sub-word loads
        do_req(1'b0, F3_B, 32'h13, 32'd0, 0);
        chk("lb_data", r_rdata, 32'hFFFFFFDE);
        chk("lb_lat", 32'(r_lat), 32'd3);
        do_req(1'b0, F3_BU, 32'h11, 32'd0, 0);
        chk("lbu_data", r_rdata, 32'h000000BE);
        chk("lbu_lat", 32'(r_lat), 32'd3);
        do_req(1'b0, F3_H, 32'h12, 32'd0, 0);
        chk("lh_data", r_rdata, 32'hFFFFDEAD);
        chk("lh_lat", 32'(r_lat), 32'd3);
        do_req(1'b0, F3_HU, 32'h10, 32'd0, 0);
        chk("lhu_data", r_rdata, 32'h0000BEEF);
        chk("lhu_nrd", 32'(r_nrd), 32'd1);

        // Byte store read-modify-write
        do_req(1'b1, F3_B, 32'h11, 32'h00000055, 0);
        chk("sb_lat", 32'(r_lat), 32'd4);
        chk("sb_nrd", 32'(r_nrd), 32'd1);
        chk("sb_nwr", 32'(r_nwr), 32'd1);
        chk("sb_wdata", last_wdata, 32'hDEAD55EF);
        chk("sb_rdata", r_rdata, 32'd0);
        do_req(1'b0, F3_W, 32'h10, 32'd0, 0);
        chk("lw_after_sb", r_rdata, 32'hDEAD55EF);

        // Halfword store into upper half
        do_req(1'b1, F3_H, 32'h12, 32'hFFFF1234, 0);
        chk("sh_wdata", last_wdata, 32'h123455EF);
        chk("sh_waddr", last_waddr, 32'd4);

        // Last in-range word
        do_req(1'b1, F3_W, 32'hFC, 32'h0BADF00D, 0);
        chk("sw63_waddr", last_waddr, 32'd63);
        do_req(1'b0, F3_W, 32'hFC, 32'd0, 0);
        chk("lw63_err", {31'd0, r_err}, 32'd0);
        chk("lw63_data", r_rdata, 32'h0BADF00D);

        // Error cases: misaligned, out of range, illegal funct3
        do_req(1'b0, F3_W, 32'h12, 32'd0, 0);
        chk("lw_mis_err", {31'd0, r_err}, 32'd1);
        chk("lw_mis_lat", 32'(r_lat), 32'd1);
        chk("lw_mis_rdata", r_rdata, 32'd0);
        chk("lw_mis_strb", 32'(r_nrd + r_nwr), 32'd0);
        do_req(1'b1, F3_H, 32'h13, 32'h1111, 0);
        chk("sh_mis_err", {31'd0, r_err}, 32'd1);
        chk("sh_mis_strb", 32'(r_nrd + r_nwr), 32'd0);
        do_req(1'b0, F3_W, 32'h100, 32'd0, 0);
        chk("lw_oor_err", {31'd0, r_err}, 32'd1);
        chk("lw_oor_lat", 32'(r_lat), 32'd1);
        chk("lw_oor_strb", 32'(r_nrd + r_nwr), 32'd0);
        do_req(1'b0, 3'b011, 32'h10, 32'd0, 0);
        chk("ld_f3_err", {31'd0, r_err}, 32'd1);
        do_req(1'b1, F3_BU, 32'h10, 32'd0, 0);
        chk("st_f3_err", {31'd0, r_err}, 32'd1);
        chk("st_f3_strb", 32'(r_nrd + r_nwr), 32'd0);

        // Response held by resp_ready=0, then back-to-back request
        do_req(1'b0, F3_W, 32'h10, 32'd0, 5);
        chk("hold_data", r_rdata, 32'h123455EF);
        do_req(1'b0, F3_B, 32'h10, 32'd0, 0);
        chk("b2b_data", r_rdata, 32'hFFFFFFEF);
        chk("b2b_lat", 32'(r_lat), 32'd3);

        // Reset in WAIT of a halfword store
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h10; req_wdata = 32'h0000AAAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_wait", {30'd0, mem_read, mem_write}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_nwr", 32'(wr_cnt - wr0), 32'd0);
        chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
        do_req(1'b0, F3_W, 32'h10, 32'd0, 0);
        chk("post_rst_lw", r_rdata, 32'h123455EF);
        chk("post_rst_lat", 32'(r_lat), 32'd3);

        chk("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
